// File: rtl/ram_dp_clr.sv
// -----------------------------------------------------------------------------
// ram_dp_clr
// Parametrised true dual-port synchronous RAM with registered reads and a
// hardware clear-on-reset sequencer.
//
// After reset is released, the sequencer writes CLEAR_VAL to every word, one
// word per cycle. It starts at word 0 and ends at word SIZE-1. While it runs,
// busy is high and both ports are ignored. After that the RAM enters normal
// operation.
//
// Collision rules:
//   - Same-port read and write in one cycle: write-first. dout returns din.
//   - Cross-port read of an address being written: read-first. The read
//     returns the old contents.
//   - Both ports write the same mapped address: port A wins and port B's
//     write is dropped.
//
// Optional build macro: RAM_COLLISION_FLAG_EN adds a sticky 'collision'
// output. It is set one cycle after any double write to the same address
// during normal operation. It is cleared by reset and held 0 while clearing.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   a_we / b_we    write strobes
//   a_re / b_re    read strobes
//   a_addr/b_addr  ADDR_IN_W-bit addresses; only the low $clog2(SIZE) bits
//                  are used, so upper bits alias
//   a_din / b_din  write data
//   a_dout/b_dout  registered read data; holds when there is no read
//   a_valid/b_valid  one-cycle pulse per accepted read
//   busy           high while the clear sequence runs
//   collision      (RAM_COLLISION_FLAG_EN only) sticky double-write flag
// -----------------------------------------------------------------------------
module ram_dp_clr #(
   parameter int                 SIZE      = 8192,
   parameter int                 DATA_W    = 8,
   parameter int                 ADDR_IN_W = 15,
   parameter logic [DATA_W-1:0]  CLEAR_VAL = {DATA_W{1'b0}}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_we,
   input  logic                  a_re,
   input  logic [ADDR_IN_W-1:0]  a_addr,
   input  logic [DATA_W-1:0]     a_din,
   output logic [DATA_W-1:0]     a_dout,
   output logic                  a_valid,
   input  logic                  b_we,
   input  logic                  b_re,
   input  logic [ADDR_IN_W-1:0]  b_addr,
   input  logic [DATA_W-1:0]     b_din,
   output logic [DATA_W-1:0]     b_dout,
   output logic                  b_valid,
   output logic                  busy
`ifdef RAM_COLLISION_FLAG_EN
   ,
   output logic                  collision
`endif
);

   localparam int AW = $clog2(SIZE);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t              state_r;
   state_t              next_state_s;
   logic [AW-1:0]       ptr_r;
   logic [DATA_W-1:0]   mem_r [SIZE];

   logic [AW-1:0]       a_idx_s;
   logic [AW-1:0]       b_idx_s;
   logic                run_s;
   logic                clear_last_s;
   logic                same_addr_s;
   logic                a_wr_s;
   logic                b_wr_s;
   logic                a_rd_s;
   logic                b_rd_s;

   logic [DATA_W-1:0]   a_dout_r;
   logic [DATA_W-1:0]   b_dout_r;
   logic                a_valid_r;
   logic                b_valid_r;
   logic                busy_r;

   // Upper address bits only alias; fold them into a deliberately unused net.
   generate
      if (ADDR_IN_W > AW) begin : g_addr_hi
         logic unused_addr_hi_s;
         assign unused_addr_hi_s = ^{a_addr[ADDR_IN_W-1:AW], b_addr[ADDR_IN_W-1:AW]};
      end
   endgenerate

   assign a_idx_s = a_addr[AW-1:0];
   assign b_idx_s = b_addr[AW-1:0];

   // Address decode, port qualification and next-state logic.
   always_comb begin
      next_state_s = state_r;
      run_s        = 1'b0;
      clear_last_s = 1'b0;
      same_addr_s  = (a_idx_s == b_idx_s);
      a_wr_s       = 1'b0;
      b_wr_s       = 1'b0;
      a_rd_s       = 1'b0;
      b_rd_s       = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            clear_last_s = (ptr_r == AW'(SIZE - 1));
            if (clear_last_s) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_CLEAR;
            end
         end
         ST_RUN: begin
            run_s        = 1'b1;
            next_state_s = ST_RUN;
            a_wr_s       = a_we;
            a_rd_s       = a_re;
            b_rd_s       = b_re;
            // Port A wins a same-address double write.
            if (a_we && same_addr_s) begin
               b_wr_s = 1'b0;
            end else begin
               b_wr_s = b_we;
            end
         end
         default: begin
            next_state_s = ST_CLEAR;
         end
      endcase
   end

   // FSM state register; reset always restarts the clear sequence.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_CLEAR;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Clear pointer: walks 0..SIZE-1 once per clear sequence.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r <= {AW{1'b0}};
      end else if (state_r == ST_CLEAR) begin
         ptr_r <= ptr_r + AW'(1'b1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Busy flag: registered so it falls on the same edge as the last clear write.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b1;
      end else begin
         busy_r <= (next_state_s == ST_CLEAR);
      end
   end

   // Memory array writes. The port A write comes last so it wins on equal indices.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_r == ST_CLEAR) begin
            mem_r[ptr_r] <= CLEAR_VAL;
         end else begin
            if (b_wr_s) begin
               mem_r[b_idx_s] <= b_din;
            end
            if (a_wr_s) begin
               mem_r[a_idx_s] <= a_din;
            end
         end
      end
   end

   // Port A read register: write-first on its own write, otherwise old contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_dout_r  <= {DATA_W{1'b0}};
         a_valid_r <= 1'b0;
      end else if (a_rd_s) begin
         a_dout_r  <= a_we ? a_din : mem_r[a_idx_s];
         a_valid_r <= 1'b1;
      end else begin
         a_dout_r  <= a_dout_r;
         a_valid_r <= 1'b0;
      end
   end

   // Port B read register: write-first on its own write, otherwise old contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         b_dout_r  <= {DATA_W{1'b0}};
         b_valid_r <= 1'b0;
      end else if (b_rd_s) begin
         b_dout_r  <= b_we ? b_din : mem_r[b_idx_s];
         b_valid_r <= 1'b1;
      end else begin
         b_dout_r  <= b_dout_r;
         b_valid_r <= 1'b0;
      end
   end

   assign a_dout  = a_dout_r;
   assign a_valid = a_valid_r;
   assign b_dout  = b_dout_r;
   assign b_valid = b_valid_r;
   assign busy    = busy_r;

`ifdef RAM_COLLISION_FLAG_EN
   logic collision_r;

   // Sticky double-write flag; only armed during normal operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         collision_r <= 1'b0;
      end else if (run_s && a_we && b_we && same_addr_s) begin
         collision_r <= 1'b1;
      end else begin
         collision_r <= collision_r;
      end
   end

   assign collision = collision_r;
`else
   logic unused_run_s;
   assign unused_run_s = run_s;
`endif

endmodule

// File: tb/tb_ram_dp_clr.sv
// -----------------------------------------------------------------------------
// Bench for ram_dp_clr.
//
// The main instance has SIZE=16 and an 8-bit address. A second instance uses
// the default SIZE=8192 and 15-bit address to exercise aliasing at full size.
// The stimulus task keeps an array model of the memory and a clear-cycle
// countdown. It pushes the expected read data and arrival cycle into queues.
// A negedge monitor pops those queues on every valid and checks hold, reset,
// busy and collision values.
// -----------------------------------------------------------------------------
module tb_ram_dp_clr;

   localparam int SZ = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // small instance
   logic       reset = 1'b0;
   logic       a_we = 1'b0, a_re = 1'b0, b_we = 1'b0, b_re = 1'b0;
   logic [7:0] a_addr = 8'h00, b_addr = 8'h00, a_din = 8'h00, b_din = 8'h00;
   logic [7:0] a_dout, b_dout;
   logic       a_valid, b_valid, busy;
`ifdef RAM_COLLISION_FLAG_EN
   logic       collision;
`endif

   // full-size instance
   logic        big_reset = 1'b1;
   logic        big_a_we = 1'b0, big_a_re = 1'b0, big_b_we = 1'b0, big_b_re = 1'b0;
   logic [14:0] big_a_addr = 15'h0000, big_b_addr = 15'h0000;
   logic [7:0]  big_a_din = 8'h00, big_b_din = 8'h00;
   logic [7:0]  unused_big_a_dout, big_b_dout;
   logic        unused_big_a_valid, big_b_valid, big_busy;
`ifdef RAM_COLLISION_FLAG_EN
   logic        unused_big_collision;
`endif

   ram_dp_clr #(.SIZE(SZ), .DATA_W(8), .ADDR_IN_W(8), .CLEAR_VAL(8'h00)) dut (
      .clk(clk), .reset(reset),
      .a_we(a_we), .a_re(a_re), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout), .a_valid(a_valid),
      .b_we(b_we), .b_re(b_re), .b_addr(b_addr), .b_din(b_din),
      .b_dout(b_dout), .b_valid(b_valid),
      .busy(busy)
`ifdef RAM_COLLISION_FLAG_EN
      , .collision(collision)
`endif
   );

   ram_dp_clr dut_big (
      .clk(clk), .reset(big_reset),
      .a_we(big_a_we), .a_re(big_a_re), .a_addr(big_a_addr), .a_din(big_a_din),
      .a_dout(unused_big_a_dout), .a_valid(unused_big_a_valid),
      .b_we(big_b_we), .b_re(big_b_re), .b_addr(big_b_addr), .b_din(big_b_din),
      .b_dout(big_b_dout), .b_valid(big_b_valid),
      .busy(big_busy)
`ifdef RAM_COLLISION_FLAG_EN
      , .collision(unused_big_collision)
`endif
   );

   typedef struct {
      logic [7:0] d;
      int         cyc;
   } exp_t;

   exp_t       qa[$];
   exp_t       qb[$];
   exp_t       qbig[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   bit         started = 1'b0;
   bit         big_started = 1'b0;
   bit         exp_rst = 1'b0;
   bit         exp_busy = 1'b1;
   bit         exp_coll = 1'b0;
   logic [7:0] last_a = 8'h00;
   logic [7:0] last_b = 8'h00;
   int         clear_left = 0;
   logic [7:0] mdl [SZ];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Drive one cycle, predict its effect from the behavioural rules, advance.
   task automatic step(input bit rst,
                       input bit awe, input bit are, input logic [7:0] aad, input logic [7:0] adi,
                       input bit bwe, input bit bre, input logic [7:0] bad, input logic [7:0] bdi);
      int   ai;
      int   bi;
      bit   hit;
      exp_t e;
      reset  = rst;
      a_we   = awe; a_re = are; a_addr = aad; a_din = adi;
      b_we   = bwe; b_re = bre; b_addr = bad; b_din = bdi;
      ai     = int'(aad) % SZ;
      bi     = int'(bad) % SZ;
      hit    = 1'b0;
      if (rst) begin
         clear_left = SZ;
      end else if (clear_left > 0) begin
         mdl[SZ - clear_left] = 8'h00;
         clear_left--;
      end else begin
         if (are) begin
            e.d = awe ? adi : mdl[ai];
            e.cyc = cyc + 1;
            qa.push_back(e);
         end
         if (bre) begin
            e.d = bwe ? bdi : mdl[bi];
            e.cyc = cyc + 1;
            qb.push_back(e);
         end
         hit = awe && bwe && (ai == bi);
         if (bwe) mdl[bi] = bdi;
         if (awe) mdl[ai] = adi;
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_rst  = rst;
      exp_busy = rst || (clear_left > 0);
      if (rst) exp_coll = 1'b0;
      else if (hit) exp_coll = 1'b1;
      started = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   // Monitor: pops expectations on each valid and checks holds and flags.
   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         if (exp_rst) begin
            chk("rst_a_dout", 32'(a_dout), 32'h0);
            chk("rst_b_dout", 32'(b_dout), 32'h0);
            chk("rst_a_valid", 32'(a_valid), 32'h0);
            chk("rst_b_valid", 32'(b_valid), 32'h0);
            last_a = 8'h00;
            last_b = 8'h00;
         end else begin
            if (a_valid === 1'b1) begin
               if (qa.size() == 0) begin
                  chk("a_valid_spurious", 32'(a_valid), 32'h0);
               end else begin
                  e = qa.pop_front();
                  chk("a_latency", 32'(cyc), 32'(e.cyc));
                  chk("a_dout", 32'(a_dout), 32'(e.d));
                  last_a = e.d;
               end
            end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
               chk("a_valid_missing", 32'(a_valid), 32'h1);
               void'(qa.pop_front());
            end else begin
               chk("a_hold", 32'(a_dout), 32'(last_a));
            end
            if (b_valid === 1'b1) begin
               if (qb.size() == 0) begin
                  chk("b_valid_spurious", 32'(b_valid), 32'h0);
               end else begin
                  e = qb.pop_front();
                  chk("b_latency", 32'(cyc), 32'(e.cyc));
                  chk("b_dout", 32'(b_dout), 32'(e.d));
                  last_b = e.d;
               end
            end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
               chk("b_valid_missing", 32'(b_valid), 32'h1);
               void'(qb.pop_front());
            end else begin
               chk("b_hold", 32'(b_dout), 32'(last_b));
            end
         end
         chk("busy", 32'(busy), 32'(exp_busy));
`ifdef RAM_COLLISION_FLAG_EN
         chk("collision", 32'(collision), 32'(exp_coll));
`endif
      end
      if (big_started && big_b_valid === 1'b1) begin
         if (qbig.size() == 0) begin
            chk("big_b_valid_spurious", 32'(big_b_valid), 32'h0);
         end else begin
            e = qbig.pop_front();
            chk("big_b_dout_alias", 32'(big_b_dout), 32'(e.d));
         end
      end
   end

   initial begin
      logic [31:0] r1;
      logic [31:0] r2;
      logic [7:0]  ra;
      logic [7:0]  rb;
      exp_t        e;

      for (int i = 0; i < SZ; i++) mdl[i] = 8'hxx;

      // power-up clear
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      idle(SZ + 1);

      // addr 9 is clear: own-port write-first vs cross-port read-first
      step(1'b0, 1'b1, 1'b1, 8'h09, 8'h3C, 1'b0, 1'b1, 8'h09, 8'h00);
      idle(1);

      // port A writes 5, port B reads it next cycle
      step(1'b0, 1'b1, 1'b0, 8'h05, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h05, 8'h00);
      idle(1);

      // double write to 7: port A wins; alias 0x17 == 7 for the read
      step(1'b0, 1'b1, 1'b0, 8'h07, 8'h11, 1'b1, 1'b0, 8'h07, 8'h22);
      step(1'b0, 1'b0, 1'b1, 8'h07, 8'h00, 1'b0, 1'b1, 8'h17, 8'h00);
      idle(2);

      // preload all words non-zero, then pulse reset and read everything back
      for (int i = 0; i < SZ; i++)
         step(1'b0, 1'b1, 1'b0, 8'(i), 8'(8'h80 + i), 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      idle(SZ);
      for (int i = 0; i < SZ; i++)
         step(1'b0, 1'b0, 1'b1, 8'(i), 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      idle(2);

      // reset; write at clear cycle 3 (ignored); reset again at clear cycle 5
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      idle(2);
      step(1'b0, 1'b1, 1'b0, 8'h02, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      idle(SZ);
      step(1'b0, 1'b0, 1'b1, 8'h02, 8'h00, 1'b0, 1'b1, 8'h12, 8'h00);
      idle(2);

      // randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         r1 = $urandom();
         r2 = $urandom();
         ra = r1[15:8];
         rb = r2[0] ? {r2[7:4], ra[3:0]} : r2[15:8];
         step(r1[31:26] == 6'd0, r1[0], r1[1], ra, r1[23:16],
              r1[2], r1[3], rb, r2[23:16]);
      end
      idle(SZ + 3);
      chk("qa_drained", 32'(qa.size()), 32'h0);
      chk("qb_drained", 32'(qb.size()), 32'h0);

      // full-size instance: clear length and address aliasing
      big_reset = 1'b1;
      @(posedge clk); #1;
      big_reset = 1'b0;
      big_started = 1'b1;
      repeat (8191) @(posedge clk);
      #1;
      chk("big_busy_last_clear", 32'(big_busy), 32'h1);
      @(posedge clk); #1;
      chk("big_busy_done", 32'(big_busy), 32'h0);
      big_a_we = 1'b1; big_a_addr = 15'h2003; big_a_din = 8'h5E;
      @(posedge clk); #1;
      big_a_we = 1'b0;
      big_b_re = 1'b1; big_b_addr = 15'h0003;
      e.d = 8'h5E; e.cyc = 0;
      qbig.push_back(e);
      @(posedge clk); #1;
      big_b_re = 1'b0;
      @(posedge clk); #1;
      chk("big_valid_one_cycle", 32'(qbig.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised true dual-port synchronous RAM. It supersedes the fixed 8-bit single-port RAM.
- Port A serves the 6502 bus. Port B serves a second master: video fetch or DMA.
- Adds registered reads with a valid strobe, defined collision rules, and a hardware clear-on-reset sequencer with a busy flag.

Parameters:
- SIZE, 8192, number of words; must be a power of two.
- DATA_W, 8, word width in bits.
- ADDR_IN_W, 15, width of the incoming address buses; must be at least $clog2(SIZE).
- CLEAR_VAL, 0, value written to every word during the clear sequence; DATA_W bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_we  in  1  port A write strobe.
- a_re  in  1  port A read strobe.
- a_addr  in  ADDR_IN_W  port A address.
- a_din  in  DATA_W  port A write data.
- a_dout  out  DATA_W  port A registered read data.
- a_valid  out  1  port A read data valid, 1-cycle pulse.
- b_we  in  1  port B write strobe.
- b_re  in  1  port B read strobe.
- b_addr  in  ADDR_IN_W  port B address.
- b_din  in  DATA_W  port B write data.
- b_dout  out  DATA_W  port B registered read data.
- b_valid  out  1  port B read data valid, 1-cycle pulse.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Address mapping: only the low $clog2(SIZE) bits of a_addr and b_addr are used. Upper bits are ignored, so addresses alias.
- Reset (while asserted):
  - FSM enters CLEAR; clear pointer is 0.
  - busy=1.
  - a_dout=b_dout=0 and a_valid=b_valid=0.
- CLEAR state:
  - Each cycle after reset deasserts, writes CLEAR_VAL to mem[ptr], then ptr increments.
  - The write of ptr=SIZE-1 is the last; the FSM then goes to RUN.
  - busy is high for exactly SIZE cycles after reset deasserts, then falls.
  - All port strobes are ignored during CLEAR: no writes, valid stays 0, dout holds.
  - Reset reasserted mid-clear restarts the sequence from ptr=0.
- RUN state, reads:
  - x_re sampled at an edge gives x_dout = mem[addr] and x_valid=1 after that edge.
  - Latency is 1 cycle. x_valid is high for one cycle per accepted read; back-to-back reads give continuous valid.
  - With no read, x_dout holds its last value and x_valid=0.
- RUN state, writes: x_we writes x_din to mem[addr] at the edge.
- Same-port read and write in one cycle: write-first; x_dout returns the newly written x_din.
- Cross-port read of an address the other port writes in the same cycle: read-first; returns the old contents.
- Both ports write the same mapped address in the same cycle: port A's data is stored; port B's write is dropped.
- Different addresses: both ports operate fully independently every cycle.

Optional Feature:
- Macro: RAM_COLLISION_FLAG_EN.
- With the macro:
  - Adds output port collision (1 bit).
  - Set one cycle after any RUN-state cycle in which a_we and b_we both hit the same mapped address.
  - Sticky until reset. Cleared by reset and held 0 through CLEAR.
- Without the macro:
  - The collision port and its logic are absent.
  - Port-A-wins data behaviour is unchanged.

Test Plan:
1. SIZE=16, pulse reset 1 cycle, with memory pre-loaded non-zero via backdoor.
   - busy stays high 16 cycles, then low.
   - Port A reads of addresses 0..15 all return 0x00, each with a_valid after 1 cycle.
2. RUN: port A writes addr 5 = 0xA5; next cycle port B reads addr 5.
   - b_dout=0xA5 and b_valid=1 exactly one cycle after the read strobe.
3. SIZE=8192: port A writes addr 0x2003 = 0x5E; port B reads 0x0003.
   - Returns 0x5E (aliasing).
4. Same cycle: port A writes addr 7 = 0x11 and port B writes addr 7 = 0x22; then read addr 7.
   - Returns 0x11.
   - collision=1 from the next cycle if RAM_COLLISION_FLAG_EN is set, and stays 1 until reset.
5. Addr 9 holds 0x00. Same cycle: port A writes addr 9 = 0x3C with a_re=1, and port B reads addr 9.
   - a_dout=0x3C.
   - b_dout=0x00.
6. SIZE=16: reset, then a write of addr 2 = 0xFF at clear cycle 3, then reset reasserted at clear cycle 5.
   - busy stays high for a full 16 cycles after the final reset release.
   - Addr 2 reads 0x00.
